lr_shift_seq: RTL and testbench

LR_SHIFT_SEQ -- requirements
Module: lr_shift_seq

---
 rtl/lr_shift_seq.sv | 117 +++++++++++
 tb/tb_lr_shift_seq.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/lr_shift_seq.sv
// Sequential shift controller: drives an external combinational
// left/right shifter one position per cycle for up to W shifts.
module lr_shift_seq #(
  parameter int W     = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dir,
  input  logic             fill,
  input  logic [CNT_W-1:0] count,
  input  logic [W-1:0]     din,
  input  logic             abort,
  input  logic [W-1:0]     sh_out,
  output logic [W-1:0]     sh_in,
  output logic             sh_l,
  output logic             sh_r,
  output logic             sh_si,
  output logic             busy,
  output logic             done,
  output logic [W-1:0]     dout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [31:0] WMAX = W;

  state_e           state_q, state_d;
  logic [W-1:0]     work_q, work_d;
  logic [W-1:0]     dout_q, dout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_clamp;
  logic             dir_q, dir_d;
  logic             fill_q, fill_d;

  // Requests longer than the word are equivalent to a full-width shift.
  assign cnt_clamp = (32'(count) > WMAX) ? WMAX[CNT_W-1:0] : count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      dout_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      fill_q  <= fill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    dout_d  = dout_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    fill_d  = fill_q;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          work_d = din;
          cnt_d  = cnt_clamp;
          dir_d  = dir;
          fill_d = fill;
          if (cnt_clamp != '0) begin
            state_d = SHIFT;
          end else begin
            state_d = DONE;
            dout_d  = din;
          end
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          work_d = sh_out;
          cnt_d  = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_d = DONE;
            dout_d  = sh_out;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sh_in = work_q;
    sh_l  = 1'b0;
    sh_r  = 1'b0;
    sh_si = 1'b0;
    busy  = (state_q != IDLE);
    done  = (state_q == DONE);
    if (state_q == SHIFT) begin
      sh_l  = ~dir_q;
      sh_r  = dir_q;
      sh_si = fill_q;
    end
  end

  assign dout = dout_q;

endmodule

// File: tb/tb_lr_shift_seq.sv
// Bench for lr_shift_seq with a behavioural 8-bit shifter
// on the sh_* ports and a queue of expected completions.
module tb_lr_shift_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, dir, fill, abort;
  logic [3:0] count;
  logic [7:0] din, sh_out, sh_in, dout;
  logic       sh_l, sh_r, sh_si, busy, done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       dir;
    logic       fill;
    logic [3:0] count;
    logic [7:0] din;
    logic [7:0] exp;
    int         lat;
    int         nsh;
  } vec_t;

  typedef struct {
    logic [7:0] dout;
    int         lat;
    int         nsh;
    logic       dir;
  } exp_t;

  vec_t vt[8];
  exp_t sbq[$];

  always #5 clk = ~clk;

  assign sh_out = sh_l ? {sh_in[6:0], sh_si}
                : sh_r ? {sh_si, sh_in[7:1]}
                : sh_in;

  lr_shift_seq #(.W(8), .CNT_W(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .dir    (dir),
    .fill   (fill),
    .count  (count),
    .din    (din),
    .abort  (abort),
    .sh_out (sh_out),
    .sh_in  (sh_in),
    .sh_l   (sh_l),
    .sh_r   (sh_r),
    .sh_si  (sh_si),
    .busy   (busy),
    .done   (done),
    .dout   (dout)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] all_out();
    return {8'h0, busy, done, sh_l, sh_r, sh_si,
            3'b0, sh_in, dout};
  endfunction

  task automatic start_op(input logic d, input logic f,
                          input logic [3:0] c,
                          input logic [7:0] x);
    @(negedge clk);
    start = 1'b1;
    dir   = d;
    fill  = f;
    count = c;
    din   = x;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int lat,
                           output int nl, output int nr,
                           output bit got);
    lat = 0; nl = 0; nr = 0; got = 1'b0;
    for (int k = 1; k <= bound; k++) begin
      @(negedge clk);
      if (sh_l) nl++;
      if (sh_r) nr++;
      chk("excl", 32'(sh_l & sh_r), 0);
      chk("busy", 32'(busy), 1);
      if (done) begin
        lat = k;
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic finish_op(input string nm);
    int   lat, nl, nr;
    bit   got;
    exp_t e;
    wait_done(20, lat, nl, nr, got);
    if (!got || sbq.size() == 0) begin
      chk({nm, "_timeout"}, 0, 1);
      sbq.delete();
    end else begin
      e = sbq.pop_front();
      chk({nm, "_dout"}, 32'(dout), 32'(e.dout));
      chk({nm, "_lat"}, lat, e.lat);
      chk({nm, "_nsh"}, e.dir ? nr : nl, e.nsh);
      chk({nm, "_nop"}, e.dir ? nl : nr, 0);
    end
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    start_op(v.dir, v.fill, v.count, v.din);
    sbq.push_back('{v.exp, v.lat, v.nsh, v.dir});
    finish_op(nm);
  endtask

  initial begin
    int  lat;
    bit  got;

    vt[0] = '{1'b0, 1'b0, 4'd1,  8'h81, 8'h02, 2, 1};
    vt[1] = '{1'b1, 1'b1, 4'd3,  8'h00, 8'hE0, 4, 3};
    vt[2] = '{1'b0, 1'b0, 4'd0,  8'h5A, 8'h5A, 1, 0};
    vt[3] = '{1'b0, 1'b0, 4'd15, 8'hFF, 8'h00, 9, 8};
    vt[4] = '{1'b1, 1'b0, 4'd2,  8'hF0, 8'h3C, 3, 2};
    vt[5] = '{1'b0, 1'b1, 4'd4,  8'h0F, 8'hFF, 5, 4};
    vt[6] = '{1'b1, 1'b0, 4'd9,  8'hFF, 8'h00, 9, 8};
    vt[7] = '{1'b0, 1'b1, 4'd8,  8'h00, 8'hFF, 9, 8};

    rst_n = 1'b0;
    start = 1'b0; dir = 1'b0; fill = 1'b0;
    abort = 1'b0; count = 4'd0; din = 8'h00;
    #3 chk("reset_outs", all_out(), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_vec(vt[i], $sformatf("vec%0d", i));
    end

    // second start while busy must vanish
    start_op(1'b0, 1'b0, 4'd3, 8'h01);
    sbq.push_back('{8'h08, 4, 3, 1'b0});
    got = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      chk("ign_busy", 32'(busy), 1);
      if (done) begin
        got = 1'b1;
        lat = k;
        break;
      end
      start = (k == 1);
      din   = (k == 1) ? 8'h11 : 8'h00;
    end
    start = 1'b0;
    if (!got || sbq.size() == 0) begin
      chk("ign_timeout", 0, 1);
    end else begin
      exp_t e;
      e = sbq.pop_front();
      chk("ign_dout", 32'(dout), 32'(e.dout));
      chk("ign_lat", lat, e.lat);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("ign_noqueue_busy", 32'(busy), 0);
      chk("ign_noqueue_done", 32'(done), 0);
    end

    // abort in the second SHIFT cycle
    start_op(1'b1, 1'b0, 4'd5, 8'h33);
    @(negedge clk);
    chk("abt_shift1", 32'(busy), 1);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    chk("abt_idle", 32'(busy), 0);
    chk("abt_dout", 32'(dout), 32'h08);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("abt_nodone", 32'(done), 0);
    end
    chk("abt_hold", 32'(dout), 32'h08);

    // abort beats start in IDLE
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    count = 4'd0; din = 8'h77;
    @(posedge clk);
    #1 start = 1'b0;
    abort = 1'b0;
    chk("abt_start_busy", 32'(busy), 0);
    @(negedge clk);
    chk("abt_start_done", 32'(done), 0);
    chk("abt_start_dout", 32'(dout), 32'h08);

    // asynchronous reset in the middle of a shift run
    start_op(1'b0, 1'b1, 4'd6, 8'h00);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("rst_mid_outs", all_out(), 0);
    @(negedge clk);
    chk("rst_hold_outs", all_out(), 0);
    rst_n = 1'b1;
    start = 1'b1; dir = 1'b0; fill = 1'b0;
    count = 4'd1; din = 8'h81;
    @(posedge clk);
    #1 start = 1'b0;
    sbq.push_back('{8'h02, 2, 1, 1'b0});
    finish_op("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule
